// File: rtl/mem_rr_arbiter_if.sv
// Bundle of requester, memory-pin and status signals for mem_rr_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_rr_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          arb_en;
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          rvalid0;
    logic          rvalid1;
    logic          mem_en;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic          err_spurious;

    modport slave (
        input  arb_en, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_rdata, mem_rvalid,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
        output mem_en, mem_re, mem_addr, mem_wdata, err_spurious
    );

    modport master (
        output arb_en, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_rdata, mem_rvalid,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
        input  mem_en, mem_re, mem_addr, mem_wdata, err_spurious
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 16x32 memory with a
// one-cycle read latency; read returns are steered back to their issuing port.
module mem_rr_arbiter #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    mem_rr_arbiter_if.slave bus
);
    logic          gnt0;
    logic          gnt1;
    logic          xfer;
    logic          xfer_we;
    logic [AW-1:0] xfer_addr;
    logic [DW-1:0] xfer_wdata;
    logic          ret;

    logic          prio_q,      prio_d;
    logic          mem_en_q,    mem_en_d;
    logic          mem_re_q,    mem_re_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          tag1_vld_q,  tag1_vld_d;
    logic          tag1_port_q, tag1_port_d;
    logic          tag2_vld_q,  tag2_vld_d;
    logic          tag2_port_q, tag2_port_d;
    logic [DW-1:0] rdata0_q,    rdata0_d;
    logic [DW-1:0] rdata1_q,    rdata1_d;
    logic          rvalid0_q,   rvalid0_d;
    logic          rvalid1_q,   rvalid1_d;
    logic          err_q,       err_d;

    // prio_q=1 means port 1 has priority on contention (port 0 was granted last).
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst && bus.arb_en) begin
            if (bus.req0 && (!bus.req1 || !prio_q)) begin
                gnt0 = 1'b1;
            end else if (bus.req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        xfer       = gnt0 | gnt1;
        xfer_we    = gnt1 ? bus.we1    : bus.we0;
        xfer_addr  = gnt1 ? bus.addr1  : bus.addr0;
        xfer_wdata = gnt1 ? bus.wdata1 : bus.wdata0;

        prio_d      = xfer ? gnt0 : prio_q;
        mem_en_d    = xfer & xfer_we;
        mem_re_d    = xfer & ~xfer_we;
        mem_addr_d  = xfer ? xfer_addr  : mem_addr_q;
        mem_wdata_d = xfer ? xfer_wdata : mem_wdata_q;

        // Tag stage 1 mirrors the read on the memory pins; stage 2 lines up with mem_rvalid.
        tag1_vld_d  = xfer & ~xfer_we;
        tag1_port_d = gnt1;
        tag2_vld_d  = tag1_vld_q;
        tag2_port_d = tag1_port_q;

        ret       = tag2_vld_q & bus.mem_rvalid;
        rvalid0_d = ret & ~tag2_port_q;
        rvalid1_d = ret & tag2_port_q;
        rdata0_d  = rvalid0_d ? bus.mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? bus.mem_rdata : rdata1_q;
        err_d     = err_q | (bus.mem_rvalid & ~tag2_vld_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag1_vld_q  <= 1'b0;
            tag1_port_q <= 1'b0;
            tag2_vld_q  <= 1'b0;
            tag2_port_q <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            mem_en_q    <= mem_en_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag1_vld_q  <= tag1_vld_d;
            tag1_port_q <= tag1_port_d;
            tag2_vld_q  <= tag2_vld_d;
            tag2_port_q <= tag2_port_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            err_q       <= err_d;
        end
    end

    assign bus.gnt0         = gnt0;
    assign bus.gnt1         = gnt1;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_re       = mem_re_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.rdata0       = rdata0_q;
    assign bus.rdata1       = rdata1_q;
    assign bus.rvalid0      = rvalid0_q;
    assign bus.rvalid1      = rvalid1_q;
    assign bus.err_spurious = err_q;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a behavioural 16x32 one-cycle-latency memory.
module tb_mem_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    mem_rr_arbiter_if #(.AW(4), .DW(32)) bus ();
    mem_rr_arbiter #(.AW(4), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Memory model: writes and reads captured on the edge where mem_en/mem_re are visible.
    logic [31:0] mem [0:15];
    logic        mem_rv;
    logic        spur_inj = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rv <= 1'b0;
        end else begin
            mem_rv <= bus.mem_re;
            if (bus.mem_en) mem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rvalid = mem_rv | spur_inj;

    typedef struct {
        logic en;
        logic r0;
        logic r1;
        logic g0;
        logic g1;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic drive(input int p, input logic we, input logic [3:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    // Called right after the accept edge; the return must be visible after the 2nd following edge.
    task automatic check_return(input int p, input logic [31:0] exp, input string name);
        int          seen  = -1;
        logic [31:0] got   = '0;
        logic        other = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk({name, " en/re exclusive"}, {31'd0, bus.mem_en & bus.mem_re}, 32'd0);
            if ((p == 0) ? bus.rvalid0 : bus.rvalid1) begin
                if (seen < 0) begin
                    seen = k;
                    got  = (p == 0) ? bus.rdata0 : bus.rdata1;
                end
            end
            if ((p == 0) ? bus.rvalid1 : bus.rvalid0) other = 1'b1;
        end
        chk({name, " latency"}, seen, 32'd2);
        chk({name, " data"}, got, exp);
        chk({name, " other rvalid"}, {31'd0, other}, 32'd0);
    endtask

    task automatic do_reset();
        idle();
        step();
        step();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        bus.arb_en = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        step();
        step();
        bus.req0 = 1'b1;
        #1;
        chk("reset gnt0", {31'd0, bus.gnt0}, 32'd0);
        chk("reset mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("reset mem_re", {31'd0, bus.mem_re}, 32'd0);
        chk("reset mem_addr", {28'd0, bus.mem_addr}, 32'd0);
        chk("reset mem_wdata", bus.mem_wdata, 32'd0);
        chk("reset rdata0", bus.rdata0, 32'd0);
        chk("reset rdata1", bus.rdata1, 32'd0);
        chk("reset rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
        chk("reset err", {31'd0, bus.err_spurious}, 32'd0);
        idle();
        step();
        rst = 1'b1;
        step();

        // Grant table: reads of addr 1 / addr 2, pointer starting at port 0
        bus.we0 = 1'b0; bus.we1 = 1'b0; bus.addr0 = 4'd1; bus.addr1 = 4'd2;
        for (int i = 0; i < 10; i++) begin
            bus.arb_en = tbl[i].en;
            bus.req0   = tbl[i].r0;
            bus.req1   = tbl[i].r1;
            #1;
            chk($sformatf("tbl[%0d] gnt0", i), {31'd0, bus.gnt0}, {31'd0, tbl[i].g0});
            chk($sformatf("tbl[%0d] gnt1", i), {31'd0, bus.gnt1}, {31'd0, tbl[i].g1});
            step();
            chk($sformatf("tbl[%0d] mem_re", i), {31'd0, bus.mem_re}, {31'd0, tbl[i].g0 | tbl[i].g1});
            chk($sformatf("tbl[%0d] mem_en", i), {31'd0, bus.mem_en}, 32'd0);
        end
        bus.arb_en = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) step();

        // Single-port write then read
        drive(0, 1'b1, 4'd3, 32'hDEADBEEF);
        #1;
        chk("wr3 gnt0", {31'd0, bus.gnt0}, 32'd1);
        chk("wr3 gnt1", {31'd0, bus.gnt1}, 32'd0);
        step();
        chk("wr3 mem_en", {31'd0, bus.mem_en}, 32'd1);
        chk("wr3 mem_re", {31'd0, bus.mem_re}, 32'd0);
        chk("wr3 mem_addr", {28'd0, bus.mem_addr}, 32'd3);
        chk("wr3 mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        drive(0, 1'b0, 4'd3, 32'd0);
        #1;
        chk("rd3 gnt0", {31'd0, bus.gnt0}, 32'd1);
        step();
        idle();
        check_return(0, 32'hDEADBEEF, "rd3");

        // Contention: preload addr 1/2, reset pointer, then 6 cycles of both requesting
        drive(0, 1'b1, 4'd1, 32'h000000A1);
        step();
        idle();
        drive(1, 1'b1, 4'd2, 32'h000000B2);
        step();
        do_reset();
        for (int e = 0; e < 10; e++) begin
            if (e < 6) begin
                drive(0, 1'b0, 4'd1, 32'd0);
                drive(1, 1'b0, 4'd2, 32'd0);
                #1;
                chk($sformatf("rr[%0d] gnt0", e), {31'd0, bus.gnt0}, {31'd0, (e % 2) == 0});
                chk($sformatf("rr[%0d] gnt1", e), {31'd0, bus.gnt1}, {31'd0, (e % 2) == 1});
            end else begin
                idle();
            end
            step();
            if (e >= 2 && e - 2 < 6) begin
                chk($sformatf("rr[%0d] rvalid", e), {30'd0, bus.rvalid1, bus.rvalid0},
                    ((e - 2) % 2 == 0) ? 32'd1 : 32'd2);
                if ((e - 2) % 2 == 0) chk($sformatf("rr[%0d] rdata0", e), bus.rdata0, 32'h000000A1);
                else                  chk($sformatf("rr[%0d] rdata1", e), bus.rdata1, 32'h000000B2);
            end else begin
                chk($sformatf("rr[%0d] rvalid idle", e), {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
            end
        end

        // Pipelined mixed: port 1 write then port 0 read of the same address
        drive(1, 1'b1, 4'd5, 32'h00000011);
        #1;
        chk("mix wr gnt1", {31'd0, bus.gnt1}, 32'd1);
        step();
        idle();
        drive(0, 1'b0, 4'd5, 32'd0);
        #1;
        chk("mix rd gnt0", {31'd0, bus.gnt0}, 32'd1);
        step();
        idle();
        check_return(0, 32'h00000011, "mix");

        // Quiesce after a port 1 read accept
        drive(1, 1'b0, 4'd2, 32'd0);
        #1;
        chk("q gnt1", {31'd0, bus.gnt1}, 32'd1);
        step();
        bus.arb_en = 1'b0;
        drive(0, 1'b0, 4'd1, 32'd0);
        #1;
        chk("q off gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        check_return(1, 32'h000000B2, "q");
        chk("q off gnt late", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        bus.arb_en = 1'b1;
        #1;
        chk("q resume gnt0", {31'd0, bus.gnt0}, 32'd1);
        chk("q resume gnt1", {31'd0, bus.gnt1}, 32'd0);
        idle();
        step();

        // Reset one cycle after a port 0 read accept
        drive(0, 1'b0, 4'd3, 32'd0);
        #1;
        chk("rst rd gnt0", {31'd0, bus.gnt0}, 32'd1);
        step();
        rst = 1'b0;
        #1;
        chk("rst gnt0", {31'd0, bus.gnt0}, 32'd0);
        chk("rst mem_re", {31'd0, bus.mem_re}, 32'd0);
        chk("rst mem_addr", {28'd0, bus.mem_addr}, 32'd0);
        chk("rst rdata0", bus.rdata0, 32'd0);
        chk("rst rdata1", bus.rdata1, 32'd0);
        step();
        step();
        rst = 1'b1;
        idle();
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("rst no rvalid %0d", k), {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
        end
        chk("rst err", {31'd0, bus.err_spurious}, 32'd0);
        drive(0, 1'b0, 4'd1, 32'd0);
        drive(1, 1'b0, 4'd2, 32'd0);
        #1;
        chk("rst prio gnt0", {31'd0, bus.gnt0}, 32'd1);
        chk("rst prio gnt1", {31'd0, bus.gnt1}, 32'd0);
        idle();
        step();

        // Spurious return
        chk("spur err before", {31'd0, bus.err_spurious}, 32'd0);
        spur_inj = 1'b1;
        step();
        spur_inj = 1'b0;
        chk("spur err set", {31'd0, bus.err_spurious}, 32'd1);
        chk("spur rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
        step();
        step();
        chk("spur err sticky", {31'd0, bus.err_spurious}, 32'd1);
        chk("spur rvalid late", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Two-requester round-robin arbiter in front of the 16x32 single-port memory_16x32 block.
- Accepts one read or write command per cycle from either requester and drives the memory's write-enable, read-enable, address and write-data pins.
- Tracks the owner of each in-flight read through the memory's one-cycle read latency and returns data to that requester only.
- Lets a DMA-style agent and a CPU-style agent share the one memory instance.

Parameters:
- AW, 4, address width; must match the memory's address port.
- DW, 32, data width; must match the memory's data ports.

Ports:
- clk  in  1  single clock; all registers on rising edge.
- rst  in  1  asynchronous active-low reset.
- arb_en  in  1  1 = grants allowed; 0 = quiesce, no new grants.
- req0 / req1  in  1  requester command valid.
- we0 / we1  in  1  1 = write, 0 = read; qualified by req.
- addr0 / addr1  in  AW  command address.
- wdata0 / wdata1  in  DW  write data.
- gnt0 / gnt1  out  1  combinational accept; command transfers on an edge where req&gnt=1.
- rdata0 / rdata1  out  DW  read return data.
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdata valid.
- mem_en  out  1  to memory write enable.
- mem_re  out  1  to memory read enable.
- mem_addr  out  AW  to memory address.
- mem_wdata  out  DW  to memory write data.
- mem_rdata  in  DW  from memory data out.
- mem_rvalid  in  1  from memory output-valid flag.
- err_spurious  out  1  sticky; set when mem_rvalid=1 with no tracked read.

Behaviour:
- Reset (async, rst=0):
  - mem_en, mem_re, rvalid0/1 and err_spurious = 0; mem_addr, mem_wdata, rdata0/1 = 0.
  - Pointer set to "port 0 has priority"; both in-flight tag stages cleared.
  - Release is synchronous to clk.
- Grant (combinational), gated by arb_en=1 and rst=1:
  - Only one requesting: that port wins.
  - Both requesting: the port not granted last wins.
  - At most one gnt high per cycle.
  - Pointer updates only on an accepted transfer; idle cycles hold it.
- Requester rule: hold req, we, addr and wdata stable until gnt is seen. The arbiter does not check this.
- Issue (edge t, transfer accepted):
  - Registers mem_en=we, mem_re=~we, mem_addr and mem_wdata from the winner; visible in cycle t+1.
  - No accept: mem_en=mem_re=0.
  - mem_en and mem_re are never high together.
- Read tracking:
  - Stage-1 tag {valid, port} loads at edge t.
  - Shifts to stage-2 at edge t+1, when the memory captures the read.
  - In cycle t+2 mem_rvalid=1 is expected with stage-2 valid.
  - At edge t+2 the arbiter registers rdata<port>=mem_rdata and pulses rvalid<port>. Response is seen in cycle t+3, a fixed 3-cycle read latency from accept.
  - The other port's rdata holds its last value; its rvalid stays 0.
- Throughput: back-to-back reads are fully pipelined at 1 per cycle, mixed ports allowed. No stalls.
- Write then read, same address, consecutive accepts: the memory writes at edge t+1 and reads at edge t+2, so the read returns the new data. No hazard logic is needed.
- Mismatches:
  - mem_rvalid=1 with stage-2 invalid: set err_spurious; no rvalid pulse.
  - Stage-2 valid with mem_rvalid=0: drop the tag silently.
  - err_spurious clears only on reset.
- arb_en=0 mid-traffic: gnt forced to 0 from that cycle on; in-flight reads still complete and return. The pointer is unchanged.
- Reset mid-operation: in-flight tags are discarded; no rvalid is issued for reads accepted before reset.

Test Plan:
- Write/read single port: port 0 writes 0xDEADBEEF to addr 3, then reads addr 3 -> gnt0 high on both accepts; rvalid0 pulses 3 cycles after the read accept with rdata0=0xDEADBEEF; rvalid1 stays 0.
- Contention round-robin: req0 and req1 held high with reads of addr 1 / addr 2 for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with port 0 after reset; returns alternate with the correct owner and data.
- Pipelined mixed traffic: port 1 writes 0x11 to addr 5, port 0 reads addr 5 on the next cycle -> rdata0=0x11; mem_en and mem_re never both 1.
- Quiesce: arb_en drops on the cycle after a port 1 read accept -> gnt0/gnt1 = 0 while arb_en=0; the pending rvalid1 still arrives 3 cycles after accept.
- Reset mid-flight: assert rst the cycle after a read accept -> all outputs 0 immediately; no rvalid after release; after release, port 0 has first priority.
- Spurious return: force mem_rvalid=1 with no read issued -> err_spurious=1 and stays set; rvalid0 and rvalid1 stay 0.
